cla_byte_serial_adder: RTL
==========================

// Module: cla_byte_serial_adder
// PURPOSE
//  Multi-byte adder wrapping one carry_look_ahead_8bit instance. Accepts two
//  (8*NBYTES)-bit operands plus carry-in on a valid/ready handshake. Adds one
//  byte per clock, LSB byte first, through the shared CLA. The CLA carry-out
//  is registered and fed back as the next byte's carry-in. Presents the full
//  sum, carry-out and signed overflow on a valid/ready output handshake.
//  Sits directly upstream of the CLA: feeds it and consumes its sum/cout.
// PARAMETERS
//  NBYTES  4  operand width in bytes (W = 8*NBYTES); legal range 1..16
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      a/b/cin valid this cycle
//  in_ready   out  1      block can accept operands (high only in IDLE)
//  a          in   W      operand A
//  b          in   W      operand B
//  cin        in   1      carry-in to byte 0
//  out_valid  out  1      sum/cout/overflow valid (high only in DONE)
//  out_ready  in   1      consumer takes the result this cycle
//  sum        out  W      registered sum, (a+b+cin) mod 2^W
//  cout       out  1      carry out of bit W-1
//  overflow   out  1      two's-complement overflow of a+b+cin
// BEHAVIOUR
//  Reset (rst=1 at a clk edge): state=IDLE, idx=0, carry_q=0, sum=0, cout=0,
//   overflow=0, out_valid=0, in_ready=1. Reset overrides every other input.
//  FSM states IDLE / RUN / DONE; in_ready = (state==IDLE);
//   out_valid = (state==DONE).
//  IDLE: on in_valid&&in_ready, capture a->a_q, b->b_q, cin->carry_q; idx=0;
//   go to RUN. sum/cout/overflow keep their previous values until rewritten.
//  RUN, each clock: CLA inputs are a_q[8*idx+:8], b_q[8*idx+:8], carry_q.
//   sum[8*idx+:8] <= CLA sum; carry_q <= CLA cout; idx <= idx+1.
//   When idx==NBYTES-1: cout <= CLA cout; overflow computed; go to DONE.
//  overflow = (a_q[W-1]==b_q[W-1]) && (final sum[W-1] != a_q[W-1]).
//  Latency: out_valid rises exactly NBYTES clocks after the accept edge.
//   NBYTES=1 gives a one-cycle RUN.
//  DONE: sum/cout/overflow are held stable while out_ready=0.
//   On out_ready=1, go to IDLE. The next operand is accepted no earlier
//   than the cycle after. Throughput: 1 op per NBYTES+2 clocks minimum.
//  in_valid outside IDLE is ignored; operands are never dropped mid-op,
//   because in_ready=0 and upstream must hold the data.
//  Operand a/b changes after acceptance have no effect (a_q/b_q latched).
//  Wrap-around: a carry out of the top byte appears only on cout; sum wraps.
//  Reset mid-RUN or in DONE: aborts immediately. out_valid is not asserted
//   for the aborted op; state is IDLE on the next cycle.
//  idx width = clog2(NBYTES) (min 1); idx never exceeds NBYTES-1.
// STRUCTURE
//  Shared defines file: state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
//   and BYTE_W=8.
//  Sub-module: exactly one carry_look_ahead_8bit, combinational, instantiated
//   as-is. All other logic (FSM, operand/sum registers, idx counter) stays
//   in this module.
// TESTING (NBYTES=4 unless stated)
//  1 Reset: rst=1 for 2 clks -> out_valid=0, in_ready=1, sum=0, cout=0,
//    overflow=0.
//  2 a=32'h0000_00FF, b=32'h0000_0001, cin=0 -> 4 clks after accept:
//    sum=32'h0000_0100, cout=0, overflow=0.
//  3 a=32'hFFFF_FFFF, b=0, cin=1 -> sum=0, cout=1, overflow=0
//    (carry ripples through all 4 bytes).
//  4 a=32'h7FFF_FFFF, b=32'h0000_0001, cin=0 -> sum=32'h8000_0000, cout=0,
//    overflow=1.
//  5 Backpressure: after test 2, hold out_ready=0 for 3 clks and pulse
//    in_valid with new operands -> sum stays 32'h0000_0100, in_ready=0,
//    no new op is accepted.
//  6 Reset mid-op: accept a=32'h1234_5678, b=32'h1111_1111, assert rst on
//    the 3rd RUN clk -> out_valid never asserts, IDLE next cycle.
//    A re-issued op then returns sum=32'h2345_6789.
//  Self-check every result against a+b+cin in the bench. Repeat tests 2-4
//  with NBYTES=1 (a=8'hFF, b=8'h01 -> sum=0, cout=1).

Source files
------------

// File: rtl/cla_byte_serial_adder_pkg.sv
// Shared types and constants for the byte-serial CLA adder.
// State encodings are fixed so the FSM is easy to follow in waveforms.
package cla_byte_serial_adder_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // A single-byte adder still needs a 1-bit index register.
  function automatic int idx_width(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/carry_look_ahead_8bit.sv
// Combinational 8-bit carry-look-ahead adder; every carry is a flat
// sum-of-products of generate/propagate terms and the carry-in.
module carry_look_ahead_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] gc;
  logic [8:0] c;
  logic       prod;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    gc   = {g, cin};
    c    = '0;
    c[0] = cin;
    prod = 1'b0;
    // gc[j] is the carry source entering bit j; it survives only if every
    // bit from j up to i propagates.
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j <= i + 1; j++) begin
        prod = gc[j];
        for (int k = j; k <= i; k++) begin
          prod = prod & p[k];
        end
        c[i+1] = c[i+1] | prod;
      end
    end
    sum  = p ^ c[7:0];
    cout = c[8];
  end

endmodule

// File: rtl/cla_byte_serial_adder.sv
// Multi-byte adder that pushes one byte per clock through a shared 8-bit CLA,
// LSB first, with the registered carry fed back into the next byte.
module cla_byte_serial_adder
  import cla_byte_serial_adder_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BYTE_W*NBYTES-1:0] a,
  input  logic [BYTE_W*NBYTES-1:0] b,
  input  logic                     cin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BYTE_W*NBYTES-1:0] sum,
  output logic                     cout,
  output logic                     overflow
);

  localparam int W     = BYTE_W * NBYTES;
  localparam int IDX_W = idx_width(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [BYTE_W-1:0] cla_a;
  logic [BYTE_W-1:0] cla_b;
  logic [BYTE_W-1:0] cla_sum;
  logic              cla_cout;

  assign cla_a = a_q[BYTE_W*int'(idx_q) +: BYTE_W];
  assign cla_b = b_q[BYTE_W*int'(idx_q) +: BYTE_W];

  carry_look_ahead_8bit u_cla (
    .a    (cla_a),
    .b    (cla_b),
    .cin  (carry_q),
    .sum  (cla_sum),
    .cout (cla_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d[BYTE_W*int'(idx_q) +: BYTE_W] = cla_sum;
        carry_d = cla_cout;
        if (idx_q == LAST_IDX) begin
          cout_d  = cla_cout;
          // cla_sum[MSB] is the final sum's sign bit on the last byte.
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (cla_sum[BYTE_W-1] != a_q[W-1]);
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Operand holding registers carry no state that matters after reset.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule
